// File: rtl/ingress_sg_sched.sv
// ingress_sg_sched: collects per-channel scatter-gather descriptor writes into
// shadow registers, arms per-slot pending descriptors (slot = 2*chnl + dir) and
// offers them round-robin to a shared SG/DMA engine over a valid/ready port.
// Optional build macro INGRESS_SG_SCHED_ERR_EN enables the sticky sg_err flag
// for dropped (overflowing) arms; without it sg_err is tied low.
module ingress_sg_sched #(
    parameter int NUM_CHNL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [9:0]            wr_tdest,
    input  logic [31:0]           wr_data,
    output logic                  sg_valid,
    input  logic                  sg_ready,
    output logic [3:0]            sg_chnl,
    output logic                  sg_dir,
    output logic [31:0]           sg_len,
    output logic [63:0]           sg_addr,
    output logic [31:0]           sg_xfer_len,
    output logic [30:0]           sg_offset,
    output logic                  sg_last,
    output logic [2*NUM_CHNL-1:0] sg_pend,
    output logic                  sg_err
);
    localparam int NS = 2 * NUM_CHNL;
    localparam int SW = $clog2(NS);
    localparam int CW = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1;

    typedef struct packed {
        logic [31:0] len;
        logic [63:0] addr;
        logic [31:0] xfer;
        logic [30:0] offset;
        logic        last;
    } desc_t;

    typedef enum logic {IDLE, OFFER} state_t;

    logic           wr_vld_d, wr_vld_q;
    logic [CW-1:0]  wr_chnl_d, wr_chnl_q;
    logic [2:0]     wr_reg_d, wr_reg_q;
    logic [31:0]    wr_data_d, wr_data_q;
    logic [31:0]    shadow_d [NUM_CHNL][8];
    logic [31:0]    shadow_q [NUM_CHNL][8];
    desc_t          desc_d [NS];
    desc_t          desc_q [NS];
    logic [NS-1:0]  pend_d, pend_q;
    state_t         state_d, state_q;
    logic [SW-1:0]  last_d, last_q;
    logic [SW-1:0]  grant_d, grant_q;
    desc_t          out_d, out_q;
    logic [3:0]     chnl_d, chnl_q;
    logic           dir_d, dir_q;

    logic           arm, arm_ok, sel, found;
    logic [SW-1:0]  arm_slot, win;
    desc_t          snap;

    // Input stage: filter out-of-range/misaligned writes and register the rest
    always_comb begin
        wr_vld_d  = wr_req && (wr_tdest[1:0] == 2'b00) && !wr_tdest[5]
                    && ({28'd0, wr_tdest[9:6]} < 32'(NUM_CHNL));
        wr_chnl_d = wr_tdest[6 +: CW];
        wr_reg_d  = wr_tdest[4:2];
        wr_data_d = wr_data;
    end

    // Shadow update, arming snapshot, round-robin select and offer handshake
    always_comb begin
        int idx;
        idx      = 0;
        shadow_d = shadow_q;
        desc_d   = desc_q;
        pend_d   = pend_q;
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        out_d    = out_q;
        chnl_d   = chnl_q;
        dir_d    = dir_q;
        arm      = 1'b0;
        arm_slot = '0;
        snap     = '0;
        sel      = 1'b0;
        found    = 1'b0;
        win      = '0;

        // the arming field comes from the incoming data, not the shadow
        if (wr_vld_q) begin
            shadow_d[wr_chnl_q][wr_reg_q] = wr_data_q;
            if (wr_reg_q == 3'd4) begin
                arm         = 1'b1;
                arm_slot    = SW'({wr_chnl_q, 1'b0});
                snap.len    = shadow_q[wr_chnl_q][0];
                snap.addr   = {shadow_q[wr_chnl_q][2], shadow_q[wr_chnl_q][1]};
                snap.xfer   = shadow_q[wr_chnl_q][3];
                snap.offset = wr_data_q[30:0];
                snap.last   = wr_data_q[31];
            end else if (wr_reg_q == 3'd7) begin
                arm         = 1'b1;
                arm_slot    = SW'({wr_chnl_q, 1'b1});
                snap.len    = shadow_q[wr_chnl_q][5];
                snap.addr   = {wr_data_q, shadow_q[wr_chnl_q][6]};
            end
        end

        // first pending slot after the last granted one
        for (int i = 1; i <= NS; i++) begin
            idx = (int'(last_q) + i) % NS;
            if (!found && pend_q[SW'(idx)]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    sel          = 1'b1;
                    state_d      = OFFER;
                    grant_d      = win;
                    out_d        = desc_q[win];
                    chnl_d       = 4'(win >> 1);
                    dir_d        = win[0];
                    pend_d[win]  = 1'b0;
                end
            end
            OFFER: begin
                if (sg_ready) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // a slot being selected this cycle is free to take the new snapshot
        arm_ok = arm && (!pend_q[arm_slot] || (sel && (win == arm_slot)));
        if (arm_ok) begin
            pend_d[arm_slot] = 1'b1;
            desc_d[arm_slot] = snap;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q  <= 1'b0;
            wr_chnl_q <= '0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            shadow_q  <= '{default: '0};
            desc_q    <= '{default: '0};
            pend_q    <= '0;
            state_q   <= IDLE;
            last_q    <= SW'(NS - 1);
            grant_q   <= '0;
            out_q     <= '0;
            chnl_q    <= '0;
            dir_q     <= 1'b0;
        end else begin
            wr_vld_q  <= wr_vld_d;
            wr_chnl_q <= wr_chnl_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            shadow_q  <= shadow_d;
            desc_q    <= desc_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            out_q     <= out_d;
            chnl_q    <= chnl_d;
            dir_q     <= dir_d;
        end
    end

`ifdef INGRESS_SG_SCHED_ERR_EN
    logic err_d, err_q;

    // Sticky overflow: an arm that found its slot already pending was dropped
    always_comb begin
        err_d = err_q | (arm && !arm_ok);
    end

    // Overflow flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign sg_err = err_q;
`else
    assign sg_err = 1'b0;
`endif

    assign sg_valid    = (state_q == OFFER);
    assign sg_chnl     = chnl_q;
    assign sg_dir      = dir_q;
    assign sg_len      = out_q.len;
    assign sg_addr     = out_q.addr;
    assign sg_xfer_len = out_q.xfer;
    assign sg_offset   = out_q.offset;
    assign sg_last     = out_q.last;
    assign sg_pend     = pend_q;

endmodule

// File: tb/tb_ingress_sg_sched.sv
// Bench for ingress_sg_sched: directed writes, a descriptor-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_ingress_sg_sched;
    localparam int NC = 4;
    localparam int NS = 2 * NC;
`ifdef INGRESS_SG_SCHED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [9:0]    wr_tdest = '0;
    logic [31:0]   wr_data = '0;
    logic          sg_ready = 1'b0;
    logic          sg_valid;
    logic [3:0]    sg_chnl;
    logic          sg_dir;
    logic [31:0]   sg_len;
    logic [63:0]   sg_addr;
    logic [31:0]   sg_xfer_len;
    logic [30:0]   sg_offset;
    logic          sg_last;
    logic [NS-1:0] sg_pend;
    logic          sg_err;

    ingress_sg_sched #(.NUM_CHNL(NC)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_tdest(wr_tdest), .wr_data(wr_data),
        .sg_valid(sg_valid), .sg_ready(sg_ready), .sg_chnl(sg_chnl), .sg_dir(sg_dir),
        .sg_len(sg_len), .sg_addr(sg_addr), .sg_xfer_len(sg_xfer_len),
        .sg_offset(sg_offset), .sg_last(sg_last), .sg_pend(sg_pend), .sg_err(sg_err)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (descriptor level) ----------------
    typedef struct packed {
        logic [31:0] len;
        logic [63:0] addr;
        logic [31:0] xfer;
        logic [30:0] off;
        logic        last;
    } d_t;
    typedef struct packed {
        logic        v;
        logic [9:0]  t;
        logic [31:0] d;
    } w_t;

    logic [31:0] sh [NC][8];
    d_t          pd [NS];
    bit          pn [NS];
    bit          m_off;
    int          m_slot, m_last;
    d_t          m_exp;
    bit          m_err;
    w_t          wq1, wq2;
    bit          rdy_p;
    bit          rst_p = 1'b1;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    logic        dut_v_p = 1'b0;
    int          glog[$];
    int          gcyc[$];
    logic [63:0] alog[$];

    task automatic m_reset();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < 8; r++) sh[c][r] = '0;
        for (int s = 0; s < NS; s++) begin
            pd[s] = '0;
            pn[s] = 1'b0;
        end
        m_off  = 1'b0;
        m_slot = 0;
        m_last = NS - 1;
        m_exp  = '0;
        m_err  = 1'b0;
    endtask

    task automatic m_arm(input int s, input d_t snap);
        if (pn[s]) m_err = 1'b1;
        else begin
            pd[s] = snap;
            pn[s] = 1'b1;
        end
    endtask

    task automatic m_write(input logic [9:0] t, input logic [31:0] d);
        int ch, rg;
        d_t sn;
        ch = int'(t[9:6]);
        rg = int'(t[5:2]);
        if (t[1:0] != 2'b00 || ch >= NC || rg >= 8) return;
        sh[ch][rg] = d;
        sn = '0;
        if (rg == 4) begin
            sn.len  = sh[ch][0];
            sn.addr = {sh[ch][2], sh[ch][1]};
            sn.xfer = sh[ch][3];
            sn.off  = d[30:0];
            sn.last = d[31];
            m_arm(2 * ch, sn);
        end else if (rg == 7) begin
            sn.len  = sh[ch][5];
            sn.addr = {d, sh[ch][6]};
            m_arm(2 * ch + 1, sn);
        end
    endtask

    // Model advance and compare, one step per cycle on the falling edge
    always @(negedge clk) begin
        bit f;
        logic [NS-1:0] pv;
        cyc++;
        if (rst_p) begin
            m_reset();
            wq2 = '0;
        end else begin
            if (!m_off) begin
                f = 1'b0;
                for (int i = 1; i <= NS; i++) begin
                    if (!f && pn[(m_last + i) % NS]) begin
                        f      = 1'b1;
                        m_slot = (m_last + i) % NS;
                    end
                end
                if (f) begin
                    m_off      = 1'b1;
                    m_exp      = pd[m_slot];
                    pn[m_slot] = 1'b0;
                end
            end else if (rdy_p) begin
                m_off  = 1'b0;
                m_last = m_slot;
            end
            if (wq2.v) m_write(wq2.t, wq2.d);
            wq2 = wq1;
        end
        wq1   = {wr_req, wr_tdest, wr_data};
        rdy_p = sg_ready;
        rst_p = rst;

        if (chk_en) begin
            for (int s = 0; s < NS; s++) pv[s] = pn[s];
            chk("cyc_valid", sg_valid, m_off);
            chk("cyc_pend", sg_pend, pv);
            chk("cyc_err", sg_err, ERR_EN ? m_err : 1'b0);
            if (m_off) begin
                chk("cyc_chnl", sg_chnl, m_slot / 2);
                chk("cyc_dir", sg_dir, m_slot % 2);
                chk("cyc_len", sg_len, m_exp.len);
                chk("cyc_addr", sg_addr, m_exp.addr);
                chk("cyc_xfer", sg_xfer_len, m_exp.xfer);
                chk("cyc_off", sg_offset, m_exp.off);
                chk("cyc_last", sg_last, m_exp.last);
            end
            if (sg_valid === 1'b1 && dut_v_p !== 1'b1) begin
                glog.push_back(int'(sg_chnl) * 2 + int'(sg_dir));
                gcyc.push_back(cyc);
                alog.push_back(sg_addr);
            end
        end
        dut_v_p = sg_valid;
    end

    // ---------------- stimulus ----------------
    task automatic wr_raw(input logic [9:0] t, input logic [31:0] d);
        wr_req   = 1'b1;
        wr_tdest = t;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        wr_raw({4'(ch), 4'(rg), 2'b00}, d);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        step(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", sg_valid, 0);
        chk("rst_pend", sg_pend, 0);
        chk("rst_addr", sg_addr, 0);
        chk("rst_len", sg_len, 0);
        chk("rst_err", sg_err, 0);

        // Ch1 RX descriptor and its 3-cycle arm-to-offer latency
        wr(1, 0, 32'h0000_1000);
        wr(1, 1, 32'h2000_0000);
        wr(1, 2, 32'h0000_0001);
        wr(1, 3, 32'h0000_0800);
        wr(1, 4, 32'h8000_0010);
        chk("t1_lat_n1", sg_valid, 0);
        step(1);
        chk("t1_lat_n2", sg_valid, 0);
        step(1);
        chk("t1_lat_n3", sg_valid, 1);
        chk("t1_chnl", sg_chnl, 1);
        chk("t1_dir", sg_dir, 0);
        chk("t1_len", sg_len, 64'h1000);
        chk("t1_addr", sg_addr, 64'h1_2000_0000);
        chk("t1_xfer", sg_xfer_len, 64'h800);
        chk("t1_off", sg_offset, 64'h10);
        chk("t1_last", sg_last, 1);
        step(2);
        sg_ready = 1'b1;
        step(3);

        // three arms back to back, ready held high
        glog.delete();
        gcyc.delete();
        wr(0, 4, 32'h5);
        wr(0, 7, 32'h6);
        wr(2, 4, 32'h7);
        step(10);
        chk("t2_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("t2_g0", glog[0], 0);
            chk("t2_g1", glog[1], 1);
            chk("t2_g2", glog[2], 4);
            chk("t2_gap01", gcyc[1] - gcyc[0], 2);
            chk("t2_gap12", gcyc[2] - gcyc[1], 2);
        end

        // overflow: ch3 TX armed while offered and again while pending
        sg_ready = 1'b0;
        glog.delete();
        alog.delete();
        wr(3, 5, 32'h100);
        wr(3, 6, 32'h40);
        wr(3, 7, 32'hA);
        wr(3, 7, 32'hB);
        wr(3, 7, 32'hC);
        step(4);
        chk("t3_err", sg_err, ERR_EN);
        chk("t3_pend7", sg_pend[7], 1);
        sg_ready = 1'b1;
        step(8);
        sg_ready = 1'b0;
        chk("t3_count", glog.size(), 2);
        if (alog.size() == 2) begin
            chk("t3_first_hi", alog[0][63:32], 32'hA);
            chk("t3_second_hi", alog[1][63:32], 32'hB);
            chk("t3_second_lo", alog[1][31:0], 32'h40);
        end
        chk("t3_pend_empty", sg_pend, 0);

        // ignored writes: bad channel, bad register, misaligned
        glog.delete();
        wr_raw({4'd5, 4'd4, 2'b00}, 32'h1);
        wr_raw({4'd1, 4'd9, 2'b00}, 32'h2);
        wr_raw({4'd0, 4'd4, 2'b01}, 32'h3);
        wr_raw({4'd0, 4'd12, 2'b00}, 32'h4);
        step(6);
        chk("t4_pend", sg_pend, 0);
        chk("t4_no_offer", glog.size(), 0);
        chk("t4_valid", sg_valid, 0);

        // reset during an offer
        wr(1, 7, 32'hD);
        wr(2, 7, 32'hE);
        wr(0, 4, 32'hF);
        k = 0;
        while (sg_valid !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        chk("t5_offer", sg_valid, 1);
        chk("t5_chnl", sg_chnl, 1);
        chk("t5_dir", sg_dir, 1);
        chk("t5_pend_pre", sg_pend[5], 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_valid_after", sg_valid, 0);
        chk("t5_pend_after", sg_pend, 0);
        chk("t5_err_after", sg_err, 0);
        glog.delete();
        sg_ready = 1'b1;
        wr(2, 4, 32'h33);
        step(5);
        chk("t5_regrant_cnt", glog.size(), 1);
        if (glog.size() == 1) chk("t5_regrant", glog[0], 4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
